// File: rtl/lab3_mem_line_responder.sv
// Single-outstanding line memory responder: p_num_lines x 128-bit storage behind a val/rdy request/response pair.
// Latency: response valid p_latency+1 cycles after acceptance; request rdy held low until the response handshake completes.
module lab3_mem_line_responder #(
  parameter int p_num_lines    = 64,
  parameter int p_latency      = 2,
  parameter int p_opaque_nbits = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [166+p_opaque_nbits:0]   memreq_msg,
  input  logic                          memreq_val,
  output logic                          memreq_rdy,
  output logic [134+p_opaque_nbits:0]   memresp_msg,
  output logic                          memresp_val,
  input  logic                          memresp_rdy
);

  localparam int LP_IDX_W = $clog2(p_num_lines);
  localparam int LP_CNT_W = (p_latency < 1) ? 1 : $clog2(p_latency + 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LOAD =
    (p_latency > 0) ? LP_CNT_W'(p_latency - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [LP_CNT_W-1:0]         r_cnt;
  logic [LP_CNT_W-1:0]         w_cnt_nxt;

  logic [127:0]                r_mem [p_num_lines];
  logic [2:0]                  r_type;
  logic [p_opaque_nbits-1:0]   r_opaque;
  logic [127:0]                r_data;

  logic [2:0]                  w_req_type;
  logic [p_opaque_nbits-1:0]   w_req_opaque;
  logic [LP_IDX_W-1:0]         w_req_idx;
  logic [127:0]                w_req_data;
  logic                        w_accept;
  logic                        w_unused_bits;

  assign w_req_type   = memreq_msg[166+p_opaque_nbits -: 3];
  assign w_req_opaque = memreq_msg[163+p_opaque_nbits -: p_opaque_nbits];
  assign w_req_idx    = memreq_msg[136 +: LP_IDX_W];
  assign w_req_data   = memreq_msg[127:0];
  // len and address bits outside the line index do not affect behaviour
  assign w_unused_bits = ^{memreq_msg[163:132], memreq_msg[131:128]};

  // reset gates rdy so nothing is accepted while reset is held
  assign memreq_rdy  = (r_state == S_IDLE) & reset;
  assign memresp_val = (r_state == S_RESP);
  assign w_accept    = memreq_rdy & memreq_val;
  assign memresp_msg = {r_type, r_opaque, 4'b0000, r_data};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (p_latency == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - LP_CNT_W'(1);
        end
      end
      S_RESP: begin
        if (memresp_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // response fields are captured at acceptance and held until the next acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_type   <= '0;
      r_opaque <= '0;
      r_data   <= '0;
      for (int i = 0; i < p_num_lines; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_type   <= w_req_type;
      r_opaque <= w_req_opaque;
      r_data   <= (w_req_type == 3'd0) ? r_mem[w_req_idx] : '0;
      if (w_req_type == 3'd1) begin
        r_mem[w_req_idx] <= w_req_data;
      end
    end
  end

endmodule

// File: tb/tb_lab3_mem_line_responder.sv
// Bench: three responders (latency 2, 0, 5) driven with directed and random line transactions,
// checked against an array model of the line storage.
module tb_lab3_mem_line_responder;

  localparam int NL = 64;

  logic         clk;
  logic         rst_n;
  logic [174:0] req_msg  [3];
  logic         req_val  [3];
  logic         req_rdy  [3];
  logic [142:0] resp_msg [3];
  logic         resp_val [3];
  logic         resp_rdy [3];

  int           lat [3];
  logic [127:0] model [3][NL];
  int           n_checks;
  int           n_pass;

  lab3_mem_line_responder #(.p_num_lines(NL), .p_latency(2), .p_opaque_nbits(8)) u_dut_l2 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[0]), .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
    .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0])
  );

  lab3_mem_line_responder #(.p_num_lines(NL), .p_latency(0), .p_opaque_nbits(8)) u_dut_l0 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[1]), .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
    .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1])
  );

  lab3_mem_line_responder #(.p_num_lines(NL), .p_latency(5), .p_opaque_nbits(8)) u_dut_l5 (
    .clk(clk), .reset(rst_n),
    .memreq_msg(req_msg[2]), .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]),
    .memresp_msg(resp_msg[2]), .memresp_val(resp_val[2]), .memresp_rdy(resp_rdy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [174:0] obs, input logic [174:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < NL; j++)
        model[i][j] = '0;
  endtask

  // One full transaction on responder i; hold = cycles the consumer stalls in RESP
  // while a competing request is kept asserted.
  task automatic txn(input int i, input logic [2:0] t, input logic [7:0] op,
                     input logic [31:0] a, input logic [127:0] d, input int hold);
    logic [142:0] exp_msg;
    logic [127:0] exp_d;
    int           idx;
    int           n;
    n = 0;
    while (!req_rdy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_idle", 175'(req_rdy[i]), 175'(1));
    idx   = int'((a >> 4) % NL);
    exp_d = '0;
    if (t == 3'd0) exp_d = model[i][idx];
    else if (t == 3'd1) model[i][idx] = d;
    exp_msg = {t, op, 4'h0, exp_d};
    req_msg[i] = {t, op, a, 4'hF, d};
    req_val[i] = 1'b1;
    @(negedge clk);
    // keep a different request pending while busy; it must be ignored
    req_msg[i] = {3'd1, ~op, a, 4'h3, ~d};
    n = 1;
    while (!resp_val[i] && n < 40) begin
      chk("busy_rdy", 175'(req_rdy[i]), 175'(0));
      @(negedge clk);
      n++;
    end
    chk("latency", 175'(n), 175'(lat[i] + 1));
    chk("resp_val", 175'(resp_val[i]), 175'(1));
    chk("resp_msg", 175'(resp_msg[i]), 175'(exp_msg));
    chk("resp_rdy_low", 175'(req_rdy[i]), 175'(0));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_msg", 175'(resp_msg[i]), 175'(exp_msg));
      chk("hold_val", 175'(resp_val[i]), 175'(1));
      chk("hold_rdy", 175'(req_rdy[i]), 175'(0));
    end
    resp_rdy[i] = 1'b1;
    @(negedge clk);
    req_val[i]  = 1'b0;
    req_msg[i]  = '0;
    resp_rdy[i] = 1'b0;
    chk("rdy_after_hs", 175'(req_rdy[i]), 175'(1));
    chk("val_after_hs", 175'(resp_val[i]), 175'(0));
  endtask

  initial begin
    logic [127:0] pat_a;
    logic [127:0] rd;
    logic [31:0]  ra;
    logic [2:0]   rt;
    int           ri;
    int           sel;

    n_checks = 0;
    n_pass   = 0;
    lat[0] = 2;
    lat[1] = 0;
    lat[2] = 5;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      req_msg[i]  = '0;
      req_val[i]  = 1'b0;
      resp_rdy[i] = 1'b0;
    end

    // reset state, with a request already presented
    rst_n = 1'b0;
    req_val[0] = 1'b1;
    req_msg[0] = {3'd1, 8'hAA, 32'h40, 4'h0, {4{32'hDEADBEEF}}};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_rdy", 175'(req_rdy[i]), 175'(0));
      chk("rst_resp_val", 175'(resp_val[i]), 175'(0));
      chk("rst_resp_msg", 175'(resp_msg[i]), 175'(0));
    end
    req_val[0] = 1'b0;
    req_msg[0] = '0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("rdy_after_rst", 175'(req_rdy[i]), 175'(1));

    // read of a cleared line
    txn(0, 3'd0, 8'h11, 32'h0000_0040, '0, 0);

    // write then read within the same line
    txn(0, 3'd1, 8'h22, 32'h0000_0120, 128'h0123456789ABCDEF_FEDCBA9876543210, 0);
    txn(0, 3'd0, 8'h23, 32'h0000_012C, '0, 0);

    // index wrap
    pat_a = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    txn(0, 3'd1, 8'h30, 32'h0000_0010, pat_a, 0);
    txn(0, 3'd0, 8'h31, 32'h0000_0410, '0, 0);

    // consumer stall for 5 cycles with a competing request
    txn(0, 3'd0, 8'h40, 32'h0000_0010, '0, 5);

    // reset during WAIT after a write
    req_msg[0] = {3'd1, 8'h50, 32'h0000_0200, 4'h0, {4{32'hCAFEF00D}}};
    req_val[0] = 1'b1;
    @(negedge clk);
    req_val[0] = 1'b0;
    req_msg[0] = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_val", 175'(resp_val[0]), 175'(0));
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    chk("rdy_after_midrst", 175'(req_rdy[0]), 175'(1));
    for (int k = 0; k < 6; k++) begin
      chk("no_stale_resp", 175'(resp_val[0]), 175'(0));
      @(negedge clk);
    end
    txn(0, 3'd0, 8'h51, 32'h0000_0200, '0, 0);
    txn(0, 3'd0, 8'h52, 32'h0000_0010, '0, 0);

    // unknown type at latency 0 and 5: echo type, data 0, storage untouched
    for (int i = 1; i < 3; i++) begin
      txn(i, 3'd1, 8'h60, 32'h0000_0080, pat_a, 0);
      txn(i, 3'd7, 8'h61, 32'h0000_0080, ~pat_a, 1);
      txn(i, 3'd0, 8'h62, 32'h0000_0080, '0, 0);
    end

    // random traffic over a few lines with random upper address bits
    for (int k = 0; k < 40; k++) begin
      ri  = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 4) rt = 3'd0;
      else if (sel < 8) rt = 3'd1;
      else rt = 3'($urandom_range(0, 7));
      ra = ($urandom & 32'hFFFF_FC0F) | (32'($urandom_range(0, 7)) << 4);
      rd = {$urandom, $urandom, $urandom, $urandom};
      txn(ri, rt, 8'($urandom), ra, rd, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
